// File: rtl/ovl_time_fire_cov_if.sv
// Signal bundle between the assert_time window generator/user expressions and the
// time-checker evaluation stage.
interface ovl_time_fire_cov_if #(
    parameter int unsigned CW = 32
) ();
    logic          start_event;
    logic          test_expr;
    logic          window;
    logic          window_close;
    logic          reset_on_new_start;
    logic          error_on_new_start;
    logic          xzcheck_enable;
    logic [2:0]    fire;
    logic [CW-1:0] fire_count;
    logic [CW-1:0] win_open_cnt;
    logic [CW-1:0] win_restart_cnt;
    logic [CW-1:0] win_close_cnt;

    modport master (
        output start_event, test_expr, window, window_close,
        output reset_on_new_start, error_on_new_start, xzcheck_enable,
        input  fire, fire_count, win_open_cnt, win_restart_cnt, win_close_cnt
    );

    modport slave (
        input  start_event, test_expr, window, window_close,
        input  reset_on_new_start, error_on_new_start, xzcheck_enable,
        output fire, fire_count, win_open_cnt, win_restart_cnt, win_close_cnt
    );
endinterface

// File: rtl/ovl_time_fire_cov.sv
// Evaluation stage for the assert_time checker: registered fire vector, saturating
// fire counter and coverage counters, plus a window-tracking consistency FSM.
module ovl_time_fire_cov #(
    parameter int unsigned CW              = 32,
    parameter bit          COVER_BASIC_ON  = 1'b1,
    parameter bit          COVER_CORNER_ON = 1'b1
) (
    input logic                clk,
    input logic                reset_n,
    ovl_time_fire_cov_if.slave bus
);
    localparam logic [CW-1:0] CntMax = '1;

    typedef enum logic [0:0] {StIdle, StOpen} state_e;

    state_e state_q, state_d;

    logic open_ev, violation, illegal_start, restart_ev, close_ev;
    logic desync, xz_fire, fire0_ev, cover_ev;

    logic [2:0]    fire_q;
    logic [CW-1:0] fire_count_q, win_open_cnt_q, win_restart_cnt_q, win_close_cnt_q;

    always_comb begin
        open_ev       = !bus.window & bus.start_event;
        violation     = bus.window & (bus.test_expr == 1'b0);
        illegal_start = bus.window & bus.start_event & bus.error_on_new_start;
        restart_ev    = bus.window & bus.start_event & bus.reset_on_new_start;
        close_ev      = bus.window & bus.window_close & !restart_ev;
    end

    // Unknown start_event or test_expr takes precedence over the 2-state result.
    always_comb begin
        xz_fire = bus.xzcheck_enable &
                  (((^bus.start_event) === 1'bx) |
                   (bus.window & ((^bus.test_expr) === 1'bx)));
    end

    // Window tracking FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Window tracking FSM: next state; a fresh open wins over a desync drop
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (open_ev) state_d = StOpen;
            StOpen: begin
                if (!bus.window)   state_d = open_ev ? StOpen : StIdle;
                else if (close_ev) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Window tracking FSM: outputs
    always_comb begin
        desync = 1'b0;
        unique case (state_q)
            StIdle:  desync = 1'b0;
            StOpen:  desync = !bus.window;
            default: desync = 1'b0;
        endcase
    end

    always_comb begin
        fire0_ev = (violation | illegal_start | desync) & !xz_fire;
        cover_ev = (COVER_BASIC_ON & open_ev) | (COVER_CORNER_ON & (restart_ev | close_ev));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fire_q            <= '0;
            fire_count_q      <= '0;
            win_open_cnt_q    <= '0;
            win_restart_cnt_q <= '0;
            win_close_cnt_q   <= '0;
        end else begin
            fire_q <= {cover_ev, xz_fire, fire0_ev};
            if (fire0_ev && fire_count_q != CntMax) begin
                fire_count_q <= fire_count_q + CW'(1);
            end
            if (COVER_BASIC_ON && open_ev && win_open_cnt_q != CntMax) begin
                win_open_cnt_q <= win_open_cnt_q + CW'(1);
            end
            if (COVER_CORNER_ON && restart_ev && win_restart_cnt_q != CntMax) begin
                win_restart_cnt_q <= win_restart_cnt_q + CW'(1);
            end
            if (COVER_CORNER_ON && close_ev && win_close_cnt_q != CntMax) begin
                win_close_cnt_q <= win_close_cnt_q + CW'(1);
            end
        end
    end

    assign bus.fire            = fire_q;
    assign bus.fire_count      = fire_count_q;
    assign bus.win_open_cnt    = win_open_cnt_q;
    assign bus.win_restart_cnt = win_restart_cnt_q;
    assign bus.win_close_cnt   = win_close_cnt_q;
endmodule

// File: tb/tb_ovl_time_fire_cov.sv
// Randomized and directed bench for ovl_time_fire_cov against an event-level reference
// model; a second instance with CW=2 exercises counter saturation.
module tb_ovl_time_fire_cov;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic start_event = 1'b0, test_expr = 1'b1, window = 1'b0, window_close = 1'b0;
    logic reset_on_new_start = 1'b0, error_on_new_start = 1'b0, xzcheck_enable = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raw event counts since reset, saturated at compare time.
    logic [2:0]      exp_fire;
    longint unsigned raw_fc, raw_open, raw_rst, raw_cls;
    bit              win_tracked;

    ovl_time_fire_cov_if #(.CW(32)) bus_w ();
    ovl_time_fire_cov_if #(.CW(2))  bus_s ();

    assign bus_w.start_event        = start_event;
    assign bus_w.test_expr          = test_expr;
    assign bus_w.window             = window;
    assign bus_w.window_close       = window_close;
    assign bus_w.reset_on_new_start = reset_on_new_start;
    assign bus_w.error_on_new_start = error_on_new_start;
    assign bus_w.xzcheck_enable     = xzcheck_enable;
    assign bus_s.start_event        = start_event;
    assign bus_s.test_expr          = test_expr;
    assign bus_s.window             = window;
    assign bus_s.window_close       = window_close;
    assign bus_s.reset_on_new_start = reset_on_new_start;
    assign bus_s.error_on_new_start = error_on_new_start;
    assign bus_s.xzcheck_enable     = xzcheck_enable;

    ovl_time_fire_cov #(.CW(32)) dut_w (.clk(clk), .reset_n(reset_n), .bus(bus_w));
    ovl_time_fire_cov #(.CW(2))  dut_s (.clk(clk), .reset_n(reset_n), .bus(bus_s));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned sat(input longint unsigned v, input int w);
        longint unsigned mx;
        mx = (64'd1 << w) - 64'd1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        exp_fire = 3'b000;
        raw_fc = 0; raw_open = 0; raw_rst = 0; raw_cls = 0;
        win_tracked = 1'b0;
    endtask

    // Apply the event rules to the inputs that the next edge will sample.
    task automatic model_step();
        bit op, viol, ill, rs, cl, desync, xz, f0, f2;
        op     = !window && (start_event === 1'b1);
        viol   = window && (test_expr === 1'b0);
        ill    = window && (start_event === 1'b1) && error_on_new_start;
        rs     = window && (start_event === 1'b1) && reset_on_new_start;
        cl     = window && window_close && !rs;
        desync = win_tracked && !window;
        xz     = xzcheck_enable && ($isunknown(start_event) || (window && $isunknown(test_expr)));
        f0     = (viol || ill || desync) && !xz;
        f2     = op || rs || cl;
        exp_fire = {f2, xz, f0};
        if (f0) raw_fc++;
        if (op) raw_open++;
        if (rs) raw_rst++;
        if (cl) raw_cls++;
        win_tracked = op || (win_tracked && window && !cl);
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".fire"},       {61'd0, bus_w.fire},     {61'd0, exp_fire});
        check_eq({tag, ".fire_count"}, {32'd0, bus_w.fire_count},      sat(raw_fc, 32));
        check_eq({tag, ".open_cnt"},   {32'd0, bus_w.win_open_cnt},    sat(raw_open, 32));
        check_eq({tag, ".rst_cnt"},    {32'd0, bus_w.win_restart_cnt}, sat(raw_rst, 32));
        check_eq({tag, ".cls_cnt"},    {32'd0, bus_w.win_close_cnt},   sat(raw_cls, 32));
        check_eq({tag, ".s_fire"},     {61'd0, bus_s.fire},     {61'd0, exp_fire});
        check_eq({tag, ".s_fc"},       {62'd0, bus_s.fire_count},      sat(raw_fc, 2));
        check_eq({tag, ".s_open"},     {62'd0, bus_s.win_open_cnt},    sat(raw_open, 2));
        check_eq({tag, ".s_rst"},      {62'd0, bus_s.win_restart_cnt}, sat(raw_rst, 2));
        check_eq({tag, ".s_cls"},      {62'd0, bus_s.win_close_cnt},   sat(raw_cls, 2));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic s, input logic t, input logic w, input logic wc);
        start_event = s; test_expr = t; window = w; window_close = wc;
    endtask

    // Assert reset between edges, check the outputs clear at once, release later.
    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq({tag, ".rst_fire"}, {61'd0, bus_w.fire}, 64'd0);
        check_eq({tag, ".rst_fc"},   {32'd0, bus_w.fire_count}, 64'd0);
        check_eq({tag, ".rst_open"}, {32'd0, bus_w.win_open_cnt}, 64'd0);
        check_eq({tag, ".rst_rst"},  {32'd0, bus_w.win_restart_cnt}, 64'd0);
        check_eq({tag, ".rst_cls"},  {32'd0, bus_w.win_close_cnt}, 64'd0);
        check_eq({tag, ".rst_sopen"}, {62'd0, bus_s.win_open_cnt}, 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic open_window(input string tag, input int len);
        set_in(1'b1, 1'b1, 1'b0, 1'b0); tick({tag, ".open"});
        check_eq({tag, ".open_pulse"}, {61'd0, bus_w.fire}, 64'd4);
        for (int i = 1; i <= len; i++) begin
            set_in(1'b0, 1'b1, 1'b1, (i == len) ? 1'b1 : 1'b0);
            tick({tag, ".win"});
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic xprobe;
        longint unsigned fc0, rs0;
        model_clear();
        do_reset("init");

        // Basic open / 3-cycle window / close
        set_in(1'b0, 1'b1, 1'b0, 1'b0); tick("idle");
        open_window("basic", 3);
        tick("basic.after");
        check_eq("basic.open_cnt", {32'd0, bus_w.win_open_cnt}, 64'd1);
        check_eq("basic.cls_cnt",  {32'd0, bus_w.win_close_cnt}, 64'd1);
        check_eq("basic.fc",       {32'd0, bus_w.fire_count}, 64'd0);

        // Two consecutive violations
        fc0 = raw_fc;
        set_in(1'b1, 1'b1, 1'b0, 1'b0); tick("viol.open");
        set_in(1'b0, 1'b0, 1'b1, 1'b0); tick("viol.1");
        check_eq("viol.pulse1", {63'd0, bus_w.fire[0]}, 64'd1);
        tick("viol.2");
        check_eq("viol.pulse2", {63'd0, bus_w.fire[0]}, 64'd1);
        check_eq("viol.fc", {32'd0, bus_w.fire_count}, fc0 + 2);

        // Illegal new start, then restart
        set_in(1'b1, 1'b1, 1'b1, 1'b0); error_on_new_start = 1'b1; tick("illegal");
        check_eq("illegal.f0", {63'd0, bus_w.fire[0]}, 64'd1);
        error_on_new_start = 1'b0; reset_on_new_start = 1'b1; rs0 = raw_rst;
        tick("restart");
        check_eq("restart.f0",  {63'd0, bus_w.fire[0]}, 64'd0);
        check_eq("restart.cnt", {32'd0, bus_w.win_restart_cnt}, rs0 + 1);
        error_on_new_start = 1'b1; tick("both_modes");
        check_eq("both.fire", {61'd0, bus_w.fire}, 64'd5);
        reset_on_new_start = 1'b0; error_on_new_start = 1'b0;

        // X/Z on test_expr; a 2-state simulator turns the X into a known value
        xprobe = 1'bx;
        xzcheck_enable = 1'b1;
        fc0 = raw_fc;
        set_in(1'b0, 1'bx, 1'b1, 1'b0); tick("xz.on");
        if ($isunknown(xprobe)) begin
            check_eq("xz.fire", {61'd0, bus_w.fire}, 64'd2);
            check_eq("xz.fc",   {32'd0, bus_w.fire_count}, fc0);
        end
        xzcheck_enable = 1'b0;
        set_in(1'b0, 1'b1, 1'b1, 1'b0); tick("xz.off");
        check_eq("xz.off.f1", {63'd0, bus_w.fire[1]}, 64'd0);

        // Generator desync: window drops without close
        set_in(1'b0, 1'b1, 1'b0, 1'b0); tick("desync");
        check_eq("desync.f0", {63'd0, bus_w.fire[0]}, 64'd1);

        // Saturation of the CW=2 instance
        do_reset("sat");
        for (int k = 0; k < 5; k++) begin
            open_window("sat", 1);
            tick("sat.gap");
        end
        check_eq("sat.s_open", {62'd0, bus_s.win_open_cnt}, 64'd3);
        check_eq("sat.w_open", {32'd0, bus_w.win_open_cnt}, 64'd5);

        // Reset mid-window, then a fresh open
        set_in(1'b1, 1'b1, 1'b0, 1'b0); tick("mid.open");
        set_in(1'b0, 1'b1, 1'b1, 1'b0); tick("mid.win");
        do_reset("mid");
        set_in(1'b1, 1'b1, 1'b0, 1'b0); tick("mid.reopen");
        check_eq("mid.open_cnt", {32'd0, bus_w.win_open_cnt}, 64'd1);
        check_eq("mid.fc", {32'd0, bus_w.fire_count}, 64'd0);

        // Randomized phase
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) window = ~window;
            start_event        = ($urandom_range(0, 3) == 0);
            test_expr          = ($urandom_range(0, 7) != 0);
            window_close       = window && ($urandom_range(0, 3) == 0);
            reset_on_new_start = ($urandom_range(0, 2) == 0);
            error_on_new_start = ($urandom_range(0, 2) == 0);
            xzcheck_enable     = $urandom_range(0, 1);
            if (xzcheck_enable && window && $urandom_range(0, 9) == 0) test_expr = 1'bx;
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
